// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned WIDTH x WIDTH multiplier using one add per cycle.
// Revision: 1.0
`default_nettype none

module shift_add_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               overflow,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

  // acc_lo starts as the multiplier and fills with product bits as it shifts right.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    addend   = acc_lo_q[0] ? mcand_q : '0;
    sum      = {1'b0, acc_hi_q} + {1'b0, addend};
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d  = a;
          acc_hi_d = '0;
          acc_lo_d = b;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_hi_d = sum[WIDTH:1];
        acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN);
  assign out_valid = (state_q == S_DONE);
  assign product   = {acc_hi_q, acc_lo_q};
  assign overflow  = |acc_hi_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed checks on a 32-bit instance, random stream on an 8-bit instance.
// Revision: 1.0
`default_nettype none

module tb_shift_add_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic chk_en = 1'b0;

  logic        iv32, or32;
  logic [31:0] a32, b32;
  wire         ir32, ov32, bz32, of32;
  wire  [63:0] p32;

  logic        iv8, or8;
  logic [7:0]  a8, b8;
  wire         ir8, ov8, bz8, of8;
  wire  [15:0] p8;

  shift_add_multiplier #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .out_valid(ov32), .out_ready(or32), .product(p32), .overflow(of32), .busy(bz32)
  );

  shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .product(p8), .overflow(of8), .busy(bz8)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n8_done = 0;

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endfunction

  // Reference: a transaction accepted in idle yields a*b exactly WIDTH edges later.
  typedef enum int {M_IDLE, M_RUN, M_DONE} mst_t;

  mst_t        m32_st = M_IDLE;
  int          m32_cnt = 0;
  logic [31:0] m32_a = '0, m32_b = '0;
  logic [63:0] m32_p = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m32_st <= M_IDLE;
      m32_p  <= '0;
    end else begin
      case (m32_st)
        M_IDLE: if (iv32) begin
          m32_a <= a32; m32_b <= b32; m32_cnt <= 0; m32_st <= M_RUN;
        end
        M_RUN: begin
          m32_cnt <= m32_cnt + 1;
          if (m32_cnt + 1 == 32) begin
            m32_st <= M_DONE;
            m32_p  <= 64'(m32_a) * 64'(m32_b);
          end
        end
        default: if (or32) m32_st <= M_IDLE;
      endcase
    end
  end

  mst_t        m8_st = M_IDLE;
  int          m8_cnt = 0;
  logic [7:0]  m8_a = '0, m8_b = '0;
  logic [15:0] m8_p = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m8_st <= M_IDLE;
      m8_p  <= '0;
    end else begin
      case (m8_st)
        M_IDLE: if (iv8) begin
          m8_a <= a8; m8_b <= b8; m8_cnt <= 0; m8_st <= M_RUN;
        end
        M_RUN: begin
          m8_cnt <= m8_cnt + 1;
          if (m8_cnt + 1 == 8) begin
            m8_st <= M_DONE;
            m8_p  <= 16'(m8_a) * 16'(m8_b);
          end
        end
        default: if (or8) m8_st <= M_IDLE;
      endcase
    end
  end

  task automatic compare_loop();
    int ncyc = 0;
    int last8 = -1;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("flags32", {61'd0, ir32, bz32, ov32},
            {61'd0, m32_st == M_IDLE, m32_st == M_RUN, m32_st == M_DONE});
        if (m32_st != M_RUN) begin
          chk("prod32", p32, m32_p);
          chk("ovf32", {63'd0, of32}, {63'd0, |m32_p[63:32]});
        end
        chk("flags8", {61'd0, ir8, bz8, ov8},
            {61'd0, m8_st == M_IDLE, m8_st == M_RUN, m8_st == M_DONE});
        if (m8_st != M_RUN) begin
          chk("prod8", {48'd0, p8}, {48'd0, m8_p});
          chk("ovf8", {63'd0, of8}, {63'd0, |m8_p[15:8]});
        end
        if (ov8) begin
          n8_done++;
          if (last8 >= 0) chk("tput8", 64'(ncyc - last8), 64'd10);
          last8 = ncyc;
        end
        ncyc++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start32(input logic [31:0] av, input logic [31:0] bv);
    iv32 = 1'b1; a32 = av; b32 = bv;
    tick();
    iv32 = 1'b0; a32 = $urandom; b32 = $urandom;
  endtask

  task automatic wait_done32(output int lat);
    lat = 0;
    while (!ov32 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  int lat;
  int k;

  initial begin
    fork
      compare_loop();
    join_none
    rst_n = 1'b0; iv32 = 1'b0; or32 = 1'b1; a32 = '0; b32 = '0;
    iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0;
    tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    chk("rst_product", p32, 64'd0);
    chk("rst_in_ready", {63'd0, ir32}, 64'd1);

    start32(32'd3, 32'd5);
    wait_done32(lat);
    chk("lat_3x5", 64'(lat), 64'd32);
    chk("p_3x5", p32, 64'h0000_0000_0000_000F);
    chk("ovf_3x5", {63'd0, of32}, 64'd0);
    tick();
    chk("idle_after_3x5", {63'd0, ir32}, 64'd1);
    chk("hold_3x5", p32, 64'hF);

    start32(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done32(lat);
    chk("p_max", p32, 64'hFFFF_FFFE_0000_0001);
    chk("ovf_max", {63'd0, of32}, 64'd1);
    tick();

    start32(32'd0, 32'hDEAD_BEEF);
    wait_done32(lat);
    chk("lat_zero", 64'(lat), 64'd32);
    chk("p_zero", p32, 64'd0);
    tick();

    or32 = 1'b0;
    start32(32'h1234_5678, 32'h9ABC_DEF0);
    wait_done32(lat);
    for (int i = 0; i < 10; i++) begin
      iv32 = ~iv32; a32 = $urandom; b32 = $urandom;
      tick();
      chk("bp_valid", {63'd0, ov32}, 64'd1);
      chk("bp_ready", {63'd0, ir32}, 64'd0);
      chk("bp_stable", p32, 64'h0B00_EA4E_242D_2080);
    end
    iv32 = 1'b1; a32 = 32'd2; b32 = 32'd3; or32 = 1'b1;
    tick();
    chk("no_accept_in_done", {62'd0, ir32, bz32}, 64'b10);
    tick();
    iv32 = 1'b0;
    chk("accept_next", {63'd0, bz32}, 64'd1);
    wait_done32(lat);
    chk("lat_2x3", 64'(lat), 64'd32);
    chk("p_2x3", p32, 64'd6);
    tick();

    start32(32'h0000_ABCD, 32'h0000_1234);
    repeat (10) tick();
    rst_n = 1'b0; iv32 = 1'b1; a32 = 32'd11; b32 = 32'd13;
    tick();
    rst_n = 1'b1; iv32 = 1'b0;
    chk("abort_ready", {63'd0, ir32}, 64'd1);
    chk("abort_product", p32, 64'd0);
    repeat (40) tick();
    start32(32'd7, 32'd9);
    wait_done32(lat);
    chk("p_7x9", p32, 64'd63);
    tick();

    iv8 = 1'b1; or8 = 1'b1;
    k = 0;
    while (n8_done < 1000 && k < 10400) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      tick();
      k++;
    end
    iv8 = 1'b0;
    chk("stream_count", 64'(n8_done), 64'd1000);
    repeat (12) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
